// File: rtl/scc_delta_sigma_dac.sv
// First-order delta-sigma DAC for the SCC left mix, with click-free power-up,
// mute and unmute slewing through midscale before tracking the input directly.
module scc_delta_sigma_dac #(
    parameter int RAMP_SHIFT = 4
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [10:0] left_in,
    input  logic        mute,
    output logic        dac_out,
    output logic        ready
);

    localparam logic [10:0] MID = 11'd1024;
    localparam int          CW  = (RAMP_SHIFT == 0) ? 1 : RAMP_SHIFT;

    typedef enum logic [2:0] {
        ST_RAMP,
        ST_SLEW,
        ST_RUN,
        ST_FADE,
        ST_MUTED
    } state_t;

    state_t        r_state;
    logic [10:0]   r_left_q;
    logic [10:0]   r_level;
    logic [10:0]   r_acc;
    logic [CW-1:0] r_tick_cnt;
    logic          r_dac;
    logic          r_ready;
    logic          w_tick;
    logic [11:0]   w_sum;

    function automatic logic [10:0] step_toward(input logic [10:0] cur,
                                                input logic [10:0] tgt);
        if (cur < tgt) return cur + 11'd1;
        if (cur > tgt) return cur - 11'd1;
        return cur;
    endfunction

    // A shift of zero means every clock is a slew tick.
    assign w_tick = (RAMP_SHIFT == 0) ? 1'b1 : (&r_tick_cnt);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_tick_cnt <= '0;
            r_left_q   <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CW'(1);
            r_left_q   <= left_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state <= ST_RAMP;
            r_level <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_RAMP: begin
                    if (w_tick) r_level <= step_toward(r_level, MID);
                    if (r_level == MID) r_state <= mute ? ST_MUTED : ST_SLEW;
                end
                ST_SLEW: begin
                    if (w_tick) r_level <= step_toward(r_level, r_left_q);
                    if (mute) begin
                        r_state <= ST_FADE;
                    end else if (r_level == r_left_q) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_level <= r_left_q;
                    if (mute) r_state <= ST_FADE;
                    else      r_ready <= 1'b1;
                end
                ST_FADE: begin
                    if (w_tick) r_level <= step_toward(r_level, MID);
                    if (!mute)               r_state <= ST_SLEW;
                    else if (r_level == MID) r_state <= ST_MUTED;
                end
                ST_MUTED: begin
                    r_level <= MID;
                    if (!mute) r_state <= ST_SLEW;
                end
                default: r_state <= ST_RAMP;
            endcase
        end
    end

    // Modulator: the carry out of the 11-bit accumulator is the output bit.
    assign w_sum = {1'b0, r_acc} + {1'b0, r_level};

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_acc <= '0;
            r_dac <= 1'b0;
        end else begin
            r_acc <= w_sum[10:0];
            r_dac <= w_sum[11];
        end
    end

    assign dac_out = r_dac;
    assign ready   = r_ready;

endmodule

// File: tb/tb_scc_delta_sigma_dac.sv
// Directed bench for scc_delta_sigma_dac: one instance with per-clock slewing,
// one with a 4-clock slew period for the mute/unmute sequences.
module tb_scc_delta_sigma_dac;

    logic        clk = 1'b0;
    logic        nreset0, mute0, dac0, ready0;
    logic [10:0] left0;
    logic        nreset2, mute2, dac2, ready2;
    logic [10:0] left2;

    int n_vec = 0;
    int n_bad = 0;

    scc_delta_sigma_dac #(.RAMP_SHIFT(0)) dut0 (
        .clk(clk), .nreset(nreset0), .left_in(left0), .mute(mute0),
        .dac_out(dac0), .ready(ready0)
    );

    scc_delta_sigma_dac #(.RAMP_SHIFT(2)) dut2 (
        .clk(clk), .nreset(nreset2), .left_in(left2), .mute(mute2),
        .dac_out(dac2), .ready(ready2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] lin;
        int          ones;
    } dens_vec_t;

    dens_vec_t dens_tbl[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int cnt, prev, d, steps, bad_step, bad_gap, gap;
        logic pdac;
        bit   done;

        dens_tbl[0] = '{11'd0,    0};
        dens_tbl[1] = '{11'd2047, 2047};
        dens_tbl[2] = '{11'd512,  512};
        dens_tbl[3] = '{11'd1024, 1024};
        dens_tbl[4] = '{11'd1,    1};
        dens_tbl[5] = '{11'd1536, 1536};
        dens_tbl[6] = '{11'd1100, 1100};

        nreset0 = 1'b0; mute0 = 1'b1; left0 = 11'd555;
        nreset2 = 1'b0; mute2 = 1'b0; left2 = 11'd1100;
        step(); step();
        chk("rst_level", int'(dut0.r_level), 0);
        chk("rst_acc", int'(dut0.r_acc), 0);
        chk("rst_dac", int'(dac0), 0);
        chk("rst_ready", int'(ready0), 0);

        // Power-up ramp, one step per clock
        nreset0 = 1'b1; mute0 = 1'b0; left0 = 11'd1024;
        for (int k = 1; k <= 1024; k++) begin
            step();
            chk("ramp_level", int'(dut0.r_level), k);
            if (ready0) chk("ramp_ready_early", 1, 0);
        end
        cnt = 0;
        while (!ready0 && cnt < 20) begin
            step();
            cnt++;
        end
        chk("ramp_ready", int'(ready0), 1);
        chk("ramp_to_run_edges", cnt, 2);
        step();
        pdac = dac0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("mid_alternate", int'(dac0), int'(!pdac));
            pdac = dac0;
        end

        // Density table
        for (int v = 0; v < 7; v++) begin
            left0 = dens_tbl[v].lin;
            repeat (2048) step();
            cnt = 0;
            for (int k = 0; k < 2048; k++) begin
                step();
                cnt += int'(dac0);
            end
            chk($sformatf("density_%0d", dens_tbl[v].lin), cnt, dens_tbl[v].ones);
        end
        chk("density_ready", int'(ready0), 1);

        // Latency: park the accumulator at a known value (2) with level 0
        left0 = 11'd1;
        repeat (3) step();
        cnt = 0;
        while (!dac0 && cnt < 2100) begin
            step();
            cnt++;
        end
        chk("lat_sync_found", int'(dac0), 1);
        left0 = 11'd0;
        repeat (5) step();
        chk("lat_acc_parked", int'(dut0.r_acc), 2);
        left0 = 11'd2047;
        step();
        chk("lat_level_n", int'(dut0.r_level), 0);
        chk("lat_dac_n", int'(dac0), 0);
        step();
        chk("lat_level_n1", int'(dut0.r_level), 2047);
        chk("lat_dac_n1", int'(dac0), 0);
        step();
        chk("lat_dac_n2", int'(dac0), 1);

        // Reset in RUN with mute high
        mute0 = 1'b1; nreset0 = 1'b0;
        step();
        chk("mrst_level", int'(dut0.r_level), 0);
        chk("mrst_acc", int'(dut0.r_acc), 0);
        chk("mrst_dac", int'(dac0), 0);
        chk("mrst_ready", int'(ready0), 0);
        nreset0 = 1'b1; mute0 = 1'b0;
        step();
        chk("mrst_ramp1", int'(dut0.r_level), 1);
        repeat (4) step();
        chk("mrst_ramp5", int'(dut0.r_level), 5);

        // Slow instance: ramp with a 4-clock tick
        nreset2 = 1'b1; mute2 = 1'b0; left2 = 11'd1100;
        repeat (400) step();
        chk("ramp2_level_400", int'(dut2.r_level), 100);
        cnt = 0;
        while (!ready2 && cnt < 6000) begin
            step();
            cnt++;
        end
        chk("ramp2_ready", int'(ready2), 1);
        chk("ramp2_level", int'(dut2.r_level), 1100);

        // Mute fade from 1100 to midscale
        mute2 = 1'b1;
        step();
        chk("fade_ready_drop", int'(ready2), 0);
        prev = int'(dut2.r_level);
        steps = 0; bad_step = 0; bad_gap = 0; gap = 0;
        cnt = 0;
        while (prev != 1024 && cnt < 400) begin
            step();
            cnt++;
            gap++;
            d = prev - int'(dut2.r_level);
            if (d != 0) begin
                if (d != 1) bad_step++;
                if (steps > 0 && gap != 4) bad_gap++;
                steps++;
                gap = 0;
            end
            prev = int'(dut2.r_level);
        end
        chk("fade_reach_mid", prev, 1024);
        chk("fade_ticks", steps, 76);
        chk("fade_bad_steps", bad_step, 0);
        chk("fade_bad_gaps", bad_gap, 0);
        repeat (20) step();
        chk("muted_hold", int'(dut2.r_level), 1024);
        chk("muted_ready", int'(ready2), 0);

        // Unmute back to 1100, then fade again and unmute mid-fade toward 900
        mute2 = 1'b0;
        cnt = 0;
        while (!ready2 && cnt < 600) begin
            step();
            cnt++;
        end
        chk("unmute_ready", int'(ready2), 1);
        chk("unmute_level", int'(dut2.r_level), 1100);
        mute2 = 1'b1;
        cnt = 0;
        while (dut2.r_level != 11'd1060 && cnt < 300) begin
            step();
            cnt++;
        end
        chk("midfade_level", int'(dut2.r_level), 1060);
        left2 = 11'd900; mute2 = 1'b0;
        prev = int'(dut2.r_level);
        bad_step = 0;
        done = 1'b0;
        cnt = 0;
        while (!done && cnt < 1000) begin
            step();
            cnt++;
            d = prev - int'(dut2.r_level);
            if (d != 0 && d != 1) bad_step++;
            prev = int'(dut2.r_level);
            done = ready2;
        end
        chk("reslew_ready", int'(ready2), 1);
        chk("reslew_level", int'(dut2.r_level), 900);
        chk("reslew_bad_steps", bad_step, 0);
        chk("reslew_slewed", int'(cnt > 600), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/scc_delta_sigma_dac.md
# scc_delta_sigma_dac

Audio output stage fed directly by the SCC core's 11-bit `left_out` mix. It converts the unsigned sample into a 1-bit first-order delta-sigma bitstream for an external RC filter. Power-up, mute and unmute are slewed through midscale so the output never steps, which keeps clicks off the filtered analog output. `ready` flags when the bitstream tracks the input directly.

## Interface
- `RAMP_SHIFT`, default 4: slew step period is 2^RAMP_SHIFT clocks. Legal range 0..8; 0 means a step on every clock.
- `clk` in 1: system clock, same clock as the SCC core.
- `nreset` in 1: reset. One clock; reset is synchronous and active-low.
- `left_in` in 11: unsigned offset-binary sample from the core's `left_out`; midscale is 1024.
- `mute` in 1: level request; 1 slews the output to midscale and holds it there.
- `dac_out` out 1: delta-sigma bitstream, registered.
- `ready` out 1: 1 only in state RUN.

## Operation
- `left_q` (11 bit) registers `left_in` on every clock.
- `level` (11 bit) is the value fed to the modulator. MID = 11'd1024.
- Slew tick counter:
  - Free-running RAMP_SHIFT-bit counter, cleared by reset.
  - `tick` = counter all ones; `tick` = 1 always when RAMP_SHIFT = 0.
- Slew step: on a `tick` clock, `level` moves 1 LSB toward the current target. With no tick, or with `level` == target, `level` holds.
- States:
  - RAMP (after reset): target is MID. When `level` == MID, go to MUTED if `mute`, else SLEW.
  - SLEW: target is `left_q`. When `level` == `left_q`, go to RUN. `mute` = 1 goes to FADE and has priority over the RUN transition.
  - RUN: `level` <= `left_q` on every clock, with no slew limit. `mute` = 1 goes to FADE.
  - FADE: target is MID. When `level` == MID, go to MUTED. `mute` = 0 goes to SLEW, with priority.
  - MUTED: `level` holds MID. `mute` = 0 goes to SLEW.
- Equality checks use the registered `level` and `left_q` before the clock edge. A state transition and a slew step can happen on the same edge.
- Modulator:
  - sum = {1'b0,acc} + {1'b0,level}, 12 bit.
  - acc <= sum[10:0].
  - dac_out <= sum[11].
  - `acc` wraps modulo 2048 by construction.
- Pulse density of `dac_out` is exactly `level`/2048 over any 2048-clock window while `level` is constant.
  - `level` = 0 gives constant 0.
  - `level` = 2047 gives one 0 per 2048 clocks.
- Reset values (`nreset` low at an edge, also mid-operation):
  - state = RAMP, `level` = 0, `acc` = 0, `left_q` = 0, tick counter = 0.
  - `dac_out` = 0, `ready` = 0.
- `mute` and `left_in` are don't-care while reset is applied.

## Timing
- `left_in` sampled at edge n reaches `level` at edge n+1 (RUN only). The first `dac_out` bit that reflects it appears at edge n+2.
- `ready` is registered with the state. It rises on the same edge that enters RUN and falls on the edge that leaves RUN.
- Power-up ramp from 0 to MID takes 1024 ticks, i.e. 1024 x 2^RAMP_SHIFT clocks (16384 at the default).
- Worst-case FADE or SLEW duration is 2047 ticks. SLEW toward a moving input ends on the first edge where the values are equal.
- No handshake: the block consumes a sample on every clock and never stalls upstream.

## Test plan
- **Reset and ramp.** RAMP_SHIFT = 0, `mute` = 0, `left_in` = 1024, release reset.
  - `level` counts 0..1024, one step per clock.
  - State goes to SLEW and then RUN; `ready` = 1 after about 1025 clocks.
  - `dac_out` then alternates 0,1,0,1.
- **Density.** In RUN, drive `left_in` = 0, then 2047, then 512, each for 4096 clocks.
  - Ones count per 2048-clock window must be 0, 2047 and 512 respectively.
- **Mute fade.** RAMP_SHIFT = 2, in RUN with `left_in` = 1100, assert `mute`.
  - `ready` drops on the next edge.
  - `level` decrements by 1 every 4 clocks and reaches 1024 after 76 ticks; state becomes MUTED.
  - `level` must never change by more than 1 per tick.
- **Unmute mid-fade.** Deassert `mute` while in FADE with `level` = 1060 and `left_in` = 900.
  - State goes to SLEW; `level` slews down to 900; then RUN with `ready` = 1.
- **Latency.** In RUN, step `left_in` from 0 to 2047 at edge n.
  - `level` = 2047 at edge n+1; `dac_out` = 1 at edge n+2.
- **Reset mid-operation.** Assert `nreset` low for one edge in RUN with `mute` = 1.
  - On the next edge all outputs and state equal their reset values and the ramp restarts from 0.
